// File: rtl/pipeline_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl_if
// Groups the hazard inputs and stall/flush outputs of the stall sequencer.
//   icache_stall  : instruction fetch not yet valid
//   dcache_stall  : stage 3/MW data access not complete
//   jump_x        : taken jump/branch resolved in stage 2/X
//   clear_count   : synchronous clear of stall_count
//   stall_pc      : hold fetch PC, no new fetch
//   stall_1_2     : stall input of the stage 1/2 transfer register
//   stall_2_3     : stall input of the stage 2/3 transfer register
//   flush_1_2     : reset (NOP load) of the stage 1/2 transfer register
//   flush_2_3     : reset (NOP load) of the stage 2/3 transfer register
//   pipe_state    : 0 INIT, 1 RUN, 2 IMISS, 3 IKILL
//   stall_count   : saturating stalled-cycle count
// master = pipeline side driving hazards, slave = the sequencer.
// -----------------------------------------------------------------------------
interface pipeline_stall_ctrl_if;
  logic        icache_stall;
  logic        dcache_stall;
  logic        jump_x;
  logic        clear_count;
  logic        stall_pc;
  logic        stall_1_2;
  logic        stall_2_3;
  logic        flush_1_2;
  logic        flush_2_3;
  logic [1:0]  pipe_state;
  logic [31:0] stall_count;

  modport master (
    output icache_stall, dcache_stall, jump_x, clear_count,
    input  stall_pc, stall_1_2, stall_2_3, flush_1_2, flush_2_3,
           pipe_state, stall_count
  );

  modport slave (
    input  icache_stall, dcache_stall, jump_x, clear_count,
    output stall_pc, stall_1_2, stall_2_3, flush_1_2, flush_2_3,
           pipe_state, stall_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
// Stall and flush sequencer for the three-stage pipeline. Resolves I-cache
// misses, D-cache misses and stage-X jumps into per-stage hold and bubble
// controls, runs a post-reset flush sequence and counts stalled cycles.
// Ports:
//   clk   : pipeline clock (state on rising edge)
//   reset : asynchronous active-low reset
//   bus   : pipeline_stall_ctrl_if.slave (hazard inputs, stall/flush outputs)
// Parameter:
//   INIT_CYCLES : forced flush cycles after reset release (1..15)
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl #(
  parameter int INIT_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  pipeline_stall_ctrl_if.slave       bus
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_IMISS = 2'd2;
  localparam logic [1:0] ST_IKILL = 2'd3;

  localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES - 1);

  logic        r_rst_meta;
  logic        r_rst_sync;
  logic [1:0]  r_state;
  logic [3:0]  r_init_cnt;
  logic [31:0] r_stall_count;

  logic [1:0]  w_state_nxt;
  logic [3:0]  w_init_cnt_nxt;
  logic        w_init;
  logic        w_stall_pc;
  logic        w_count_en;

  // Reset release synchronizer: assertion is immediate, release is seen by
  // the FSM only once it has passed through both flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt == 4'd0) w_state_nxt    = ST_RUN;
        else                    w_init_cnt_nxt = r_init_cnt - 4'd1;
      end
      ST_RUN: begin
        // A jump while a fetch is outstanding makes that fetch wrong-path;
        // under a data stall the jump is held in X and acted on later.
        if (bus.icache_stall && bus.jump_x && !bus.dcache_stall)
          w_state_nxt = ST_IKILL;
        else if (bus.icache_stall)
          w_state_nxt = ST_IMISS;
      end
      ST_IMISS: begin
        if (!bus.icache_stall)
          w_state_nxt = ST_RUN;
        else if (bus.jump_x && !bus.dcache_stall)
          w_state_nxt = ST_IKILL;
      end
      ST_IKILL: begin
        if (!bus.icache_stall) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= INIT_LOAD;
    end else if (r_rst_sync) begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // Outputs are combinational so they settle in the high phase and are valid
  // when the transfer registers latch on the falling edge.
  assign w_init     = (r_state == ST_INIT);
  assign w_stall_pc = w_init | bus.dcache_stall | bus.icache_stall;

  assign bus.stall_pc  = w_stall_pc;
  assign bus.stall_1_2 = !w_init & bus.dcache_stall;
  assign bus.stall_2_3 = !w_init & bus.dcache_stall;
  assign bus.flush_2_3 = w_init;
  // The data stall suppresses the bubble so the held instruction survives;
  // in IKILL the flush persists through the cycle the wrong-path fetch lands.
  assign bus.flush_1_2 = w_init |
                         (!bus.dcache_stall &
                          (bus.icache_stall | bus.jump_x | (r_state == ST_IKILL)));
  assign bus.pipe_state  = r_state;
  assign bus.stall_count = r_stall_count;

  assign w_count_en = !w_init & w_stall_pc & (r_stall_count != 32'hFFFF_FFFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall_count <= 32'd0;
    else if (bus.clear_count)
      r_stall_count <= 32'd0;
    else if (w_count_en)
      r_stall_count <= r_stall_count + 32'd1;
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  pipeline_stall_ctrl_if bus();

  pipeline_stall_ctrl #(.INIT_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Packed view: {stall_pc, stall_1_2, stall_2_3, flush_1_2, flush_2_3, pipe_state}
  function automatic logic [6:0] outs();
    return {bus.stall_pc, bus.stall_1_2, bus.stall_2_3,
            bus.flush_1_2, bus.flush_2_3, bus.pipe_state};
  endfunction

  task automatic set_in(input logic ic, input logic dc, input logic jx, input logic clr);
    bus.icache_stall = ic;
    bus.dcache_stall = dc;
    bus.jump_x       = jx;
    bus.clear_count  = clr;
  endtask

  task automatic clear_cnt();
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.clear_count = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (outs() !== 7'b1001100) $display("FAIL reset_outs got %b want %b", outs(), 7'b1001100);
    else n_pass++;
    n_total++;
    if (bus.stall_count !== 32'd0) $display("FAIL reset_count got %0d want 0", bus.stall_count);
    else n_pass++;
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_total++;
      if (outs() !== 7'b1001100) $display("FAIL init_outs[%0d] got %b want %b", k, outs(), 7'b1001100);
      else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_total++;
    if (outs() !== 7'b0000001) $display("FAIL run_entry got %b want %b", outs(), 7'b0000001);
    else n_pass++;
    n_total++;
    if (bus.stall_count !== 32'd0) $display("FAIL init_count got %0d want 0", bus.stall_count);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_dmiss();
    logic [2:0] vin   [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
    logic [6:0] exp_o [6] = '{7'b1110001, 7'b1110001, 7'b1110001, 7'b1110001,
                              7'b1110001, 7'b0000001};
    clear_cnt();
    for (int i = 0; i < 6; i++) begin
      set_in(vin[i][2], vin[i][1], vin[i][0], 1'b0);
      @(negedge clk);
      n_total++;
      if (outs() !== exp_o[i]) $display("FAIL dmiss_outs[%0d] got %b want %b", i, outs(), exp_o[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_total++;
    if (bus.stall_count !== 32'd5) $display("FAIL dmiss_count got %0d want 5", bus.stall_count);
    else n_pass++;
  endtask

  task automatic test_imiss();
    logic [2:0] vin   [5] = '{3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
    logic [6:0] exp_o [5] = '{7'b1001001, 7'b1001010, 7'b1001010, 7'b0000010, 7'b0000001};
    clear_cnt();
    for (int i = 0; i < 5; i++) begin
      set_in(vin[i][2], vin[i][1], vin[i][0], 1'b0);
      @(negedge clk);
      n_total++;
      if (outs() !== exp_o[i]) $display("FAIL imiss_outs[%0d] got %b want %b", i, outs(), exp_o[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_total++;
    if (bus.stall_count !== 32'd3) $display("FAIL imiss_count got %0d want 3", bus.stall_count);
    else n_pass++;
  endtask

  task automatic test_jump_during_miss();
    logic [2:0] vin   [6] = '{3'b100, 3'b101, 3'b100, 3'b100, 3'b000, 3'b000};
    logic [6:0] exp_o [6] = '{7'b1001001, 7'b1001010, 7'b1001011, 7'b1001011,
                              7'b0001011, 7'b0000001};
    clear_cnt();
    for (int i = 0; i < 6; i++) begin
      set_in(vin[i][2], vin[i][1], vin[i][0], 1'b0);
      @(negedge clk);
      n_total++;
      if (outs() !== exp_o[i]) $display("FAIL jmiss_outs[%0d] got %b want %b", i, outs(), exp_o[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_total++;
    if (bus.stall_count !== 32'd4) $display("FAIL jmiss_count got %0d want 4", bus.stall_count);
    else n_pass++;
  endtask

  task automatic test_jump_under_dstall();
    logic [2:0] vin   [4] = '{3'b011, 3'b011, 3'b001, 3'b000};
    logic [6:0] exp_o [4] = '{7'b1110001, 7'b1110001, 7'b0001001, 7'b0000001};
    clear_cnt();
    for (int i = 0; i < 4; i++) begin
      set_in(vin[i][2], vin[i][1], vin[i][0], 1'b0);
      @(negedge clk);
      n_total++;
      if (outs() !== exp_o[i]) $display("FAIL jdstall_outs[%0d] got %b want %b", i, outs(), exp_o[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_total++;
    if (bus.stall_count !== 32'd2) $display("FAIL jdstall_count got %0d want 2", bus.stall_count);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [2:0] vin   [4] = '{3'b110, 3'b111, 3'b000, 3'b000};
    logic [6:0] exp_o [4] = '{7'b1110001, 7'b1110010, 7'b0000010, 7'b0000001};
    clear_cnt();
    for (int i = 0; i < 4; i++) begin
      set_in(vin[i][2], vin[i][1], vin[i][0], 1'b0);
      @(negedge clk);
      n_total++;
      if (outs() !== exp_o[i]) $display("FAIL simul_outs[%0d] got %b want %b", i, outs(), exp_o[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_total++;
    if (bus.stall_count !== 32'd2) $display("FAIL simul_count got %0d want 2", bus.stall_count);
    else n_pass++;
  endtask

  task automatic test_saturation();
    clear_cnt();
    dut.r_stall_count = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      n_total++;
      if (bus.stall_count !== 32'hFFFF_FFFF)
        $display("FAIL sat_count[%0d] got %h want ffffffff", i, bus.stall_count);
      else n_pass++;
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    n_total++;
    if (bus.stall_count !== 32'd0) $display("FAIL clear_in_stall got %h want 0", bus.stall_count);
    else n_pass++;
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_total++;
    if (bus.stall_count !== 32'd1) $display("FAIL count_after_clear got %h want 1", bus.stall_count);
    else n_pass++;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    set_in(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_total++;
    if (outs() !== 7'b1001001) $display("FAIL midrst_jump got %b want %b", outs(), 7'b1001001);
    else n_pass++;
    @(posedge clk); #1;
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_total++;
    if (outs() !== 7'b1001011) $display("FAIL midrst_ikill got %b want %b", outs(), 7'b1001011);
    else n_pass++;
    #2;
    reset = 1'b0;
    bus.dcache_stall = 1'b1;
    #1;
    n_total++;
    if (outs() !== 7'b1001100) $display("FAIL midrst_async got %b want %b", outs(), 7'b1001100);
    else n_pass++;
    n_total++;
    if (bus.stall_count !== 32'd0) $display("FAIL midrst_count got %0d want 0", bus.stall_count);
    else n_pass++;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    n_total++;
    if (outs() !== 7'b0000001) $display("FAIL midrst_rerun got %b want %b", outs(), 7'b0000001);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_dmiss();
    test_imiss();
    test_jump_during_miss();
    test_jump_under_dstall();
    test_simultaneous();
    test_saturation();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
